tcm_dp_ctrl: RTL and testbench

Parametrised dual-port tightly-coupled memory for the RV32I pipeline: port 0 serves the data side, port 1 serves the instruction side, both byte-addressed with 4-bit byte-enable writes and one-cycle registered reads. It generalises the fixed 128 KiB TCM with configurable depth and per-port base addresses, and adds:

- out-of-range detection;
- cross-port write-first forwarding;
- a byte-stream loader FSM that initialises the array through a valid/ready handshake, replacing backdoor loading.

---
 rtl/tcm_dp_if.sv | 33 +++
 rtl/tcm_dp_ctrl.sv | 131 +++++++++++++
 tb/tb_tcm_dp_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/tcm_dp_if.sv
// Port bundle for tcm_dp_ctrl: data/instruction access ports and the byte-stream loader.
// The controller binds to the slave modport; whatever drives it binds to master.
interface tcm_dp_if;
   logic [31:0] addr0_i;
   logic [31:0] data0_i;
   logic [3:0]  wr0_i;
   logic [31:0] data0_o;
   logic        err0_o;
   logic [31:0] addr1_i;
   logic [31:0] data1_i;
   logic [3:0]  wr1_i;
   logic [31:0] data1_o;
   logic        err1_o;
   logic        ld_start_i;
   logic        ld_valid_i;
   logic [7:0]  ld_data_i;
   logic        ld_last_i;
   logic        ld_ready_o;
   logic        busy_o;
   logic        ld_ovf_o;

   modport slave (
      input  addr0_i, data0_i, wr0_i, addr1_i, data1_i, wr1_i,
      input  ld_start_i, ld_valid_i, ld_data_i, ld_last_i,
      output data0_o, err0_o, data1_o, err1_o, ld_ready_o, busy_o, ld_ovf_o
   );

   modport master (
      output addr0_i, data0_i, wr0_i, addr1_i, data1_i, wr1_i,
      output ld_start_i, ld_valid_i, ld_data_i, ld_last_i,
      input  data0_o, err0_o, data1_o, err1_o, ld_ready_o, busy_o, ld_ovf_o
   );
endinterface

// File: rtl/tcm_dp_ctrl.sv
// Dual-port byte-enabled TCM with range checking, cross-port write-first forwarding
// and a byte-stream loader that owns the array while a load is in progress.
module tcm_dp_ctrl #(
   parameter int unsigned DEPTH_LOG2 = 15,
   parameter logic [31:0] P0_BASE    = 32'h10010000,
   parameter logic [31:0] P1_BASE    = 32'h00400000
) (
   input logic      clk_i,
   input logic      rst_i,
   tcm_dp_if.slave  bus
);
   localparam int unsigned WORDS = 1 << DEPTH_LOG2;
   localparam int unsigned IW    = DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 3;

   typedef enum logic {S_IDLE, S_LOAD} state_t;

   logic [31:0]   r_mem [WORDS];
   state_t        r_state;
   logic          r_busy;
   logic          r_ready;
   logic          r_ovf;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_data0;
   logic [31:0]   r_data1;
   logic          r_err0;
   logic          r_err1;

   logic [31:0]   w_off0;
   logic [31:0]   w_off1;
   logic          w_oor0;
   logic          w_oor1;
   logic [IW-1:0] w_idx0;
   logic [IW-1:0] w_idx1;
   logic [3:0]    w_we0;
   logic [3:0]    w_we1;
   logic          w_same;
   logic          w_full;
   logic          w_ld_wr;
   logic [31:0]   w_rd0;
   logic [31:0]   w_rd1;
   logic          w_unused;

   // Offsets wrap modulo 2^32, so addresses below the base land far out of range.
   assign w_off0  = bus.addr0_i - P0_BASE;
   assign w_off1  = bus.addr1_i - P1_BASE;
   assign w_oor0  = |w_off0[31:DEPTH_LOG2+2];
   assign w_oor1  = |w_off1[31:DEPTH_LOG2+2];
   assign w_idx0  = w_off0[DEPTH_LOG2+1:2];
   assign w_idx1  = w_off1[DEPTH_LOG2+1:2];
   assign w_we0   = (r_busy || w_oor0) ? 4'b0000 : bus.wr0_i;
   assign w_we1   = (r_busy || w_oor1) ? 4'b0000 : bus.wr1_i;
   assign w_same  = (w_idx0 == w_idx1);
   assign w_full  = r_cnt[CW-1];
   assign w_ld_wr = (r_state == S_LOAD) && bus.ld_valid_i && !w_full && !rst_i;
   assign w_unused = ^{w_off0[1:0], w_off1[1:0]};

   // Write-first read data; port 0 overrides port 1 on shared lanes, matching storage.
   always_comb begin
      w_rd0 = r_mem[w_idx0];
      w_rd1 = r_mem[w_idx1];
      for (int l = 0; l < 4; l++) begin
         if (w_we1[l] && w_same) w_rd0[8*l +: 8] = bus.data1_i[8*l +: 8];
         if (w_we0[l])           w_rd0[8*l +: 8] = bus.data0_i[8*l +: 8];
         if (w_we1[l])           w_rd1[8*l +: 8] = bus.data1_i[8*l +: 8];
         if (w_we0[l] && w_same) w_rd1[8*l +: 8] = bus.data0_i[8*l +: 8];
      end
   end

   // Array is never reset; port 0 lanes are written last so they win collisions.
   always_ff @(posedge clk_i) begin
      if (w_ld_wr) r_mem[r_cnt[CW-2:2]][{r_cnt[1:0], 3'b000} +: 8] <= bus.ld_data_i;
      for (int l = 0; l < 4; l++) begin
         if (w_we1[l]) r_mem[w_idx1][8*l +: 8] <= bus.data1_i[8*l +: 8];
      end
      for (int l = 0; l < 4; l++) begin
         if (w_we0[l]) r_mem[w_idx0][8*l +: 8] <= bus.data0_i[8*l +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
         r_data0 <= '0;
         r_data1 <= '0;
         r_err0  <= 1'b0;
         r_err1  <= 1'b0;
      end else begin
         r_data0 <= (r_busy || w_oor0) ? 32'h0 : w_rd0;
         r_data1 <= (r_busy || w_oor1) ? 32'h0 : w_rd1;
         r_err0  <= !r_busy && w_oor0;
         r_err1  <= !r_busy && w_oor1;
         case (r_state)
            S_IDLE: begin
               if (bus.ld_start_i) begin
                  r_state <= S_LOAD;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b1;
                  r_ovf   <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            S_LOAD: begin
               if (bus.ld_valid_i) begin
                  // Counter saturates at capacity; further bytes only flag overflow.
                  if (w_full) r_ovf <= 1'b1;
                  else        r_cnt <= r_cnt + CW'(1);
                  if (bus.ld_last_i) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.data0_o    = r_data0;
   assign bus.data1_o    = r_data1;
   assign bus.err0_o     = r_err0;
   assign bus.err1_o     = r_err1;
   assign bus.ld_ready_o = r_ready;
   assign bus.busy_o     = r_busy;
   assign bus.ld_ovf_o   = r_ovf;
endmodule

// File: tb/tb_tcm_dp_ctrl.sv
// Directed bench for tcm_dp_ctrl: a default-depth instance for port behaviour and
// loader/reset interplay, and a 4-word instance for loader overflow.
module tb_tcm_dp_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tcm_dp_if bus0 ();
   tcm_dp_if bus1 ();

   tcm_dp_ctrl u_dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
   tcm_dp_ctrl #(.DEPTH_LOG2(2)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

   int n_run  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [31:0] a0;
      logic [31:0] d0;
      logic [3:0]  w0;
      logic [31:0] a1;
      logic [31:0] d1;
      logic [3:0]  w1;
      logic [31:0] x0;
      logic        e0;
      logic [31:0] x1;
      logic        e1;
   } vec_t;

   vec_t       vecs [15];
   logic [7:0] prog [8] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

   function automatic vec_t mk(input logic [31:0] a0, d0, input logic [3:0] w0,
                               input logic [31:0] a1, d1, input logic [3:0] w1,
                               input logic [31:0] x0, input logic e0,
                               input logic [31:0] x1, input logic e1);
      vec_t v;
      v.a0 = a0; v.d0 = d0; v.w0 = w0; v.a1 = a1; v.d1 = d1; v.w1 = w1;
      v.x0 = x0; v.e0 = e0; v.x1 = x1; v.e1 = e1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus0.addr0_i = 32'h10010000; bus0.data0_i = '0; bus0.wr0_i = '0;
      bus0.addr1_i = 32'h00400000; bus0.data1_i = '0; bus0.wr1_i = '0;
      bus0.ld_start_i = 0; bus0.ld_valid_i = 0; bus0.ld_data_i = '0; bus0.ld_last_i = 0;
      bus1.addr0_i = 32'h10010000; bus1.data0_i = '0; bus1.wr0_i = '0;
      bus1.addr1_i = 32'h00400000; bus1.data1_i = '0; bus1.wr1_i = '0;
      bus1.ld_start_i = 0; bus1.ld_valid_i = 0; bus1.ld_data_i = '0; bus1.ld_last_i = 0;

      vecs[0]  = mk(32'h10010000, 0, 4'h0, 32'h00400000, 0, 4'h0, 32'h00000513, 0, 32'h00000513, 0);
      vecs[1]  = mk(32'h10010004, 0, 4'h0, 32'h00400004, 0, 4'h0, 32'h00100593, 0, 32'h00100593, 0);
      vecs[2]  = mk(32'h10010010, 32'h11223344, 4'hF, 32'h00400010, 0, 4'h0, 32'h11223344, 0, 32'h11223344, 0);
      vecs[3]  = mk(32'h10010010, 32'hDEADBEEF, 4'h5, 32'h00400010, 0, 4'h0, 32'h11AD33EF, 0, 32'h11AD33EF, 0);
      vecs[4]  = mk(32'h10010010, 0, 4'h0, 32'h00400000, 0, 4'h0, 32'h11AD33EF, 0, 32'h00000513, 0);
      vecs[5]  = mk(32'h10010000, 32'hCAFEBABE, 4'hF, 32'h00400000, 0, 4'h0, 32'hCAFEBABE, 0, 32'hCAFEBABE, 0);
      vecs[6]  = mk(32'h10010004, 32'h00000000, 4'hF, 32'h00400004, 0, 4'h0, 32'h00000000, 0, 32'h00000000, 0);
      vecs[7]  = mk(32'h10010004, 32'hA1A2A3A4, 4'h3, 32'h00400004, 32'hB1B2B3B4, 4'h6, 32'h00B2A3A4, 0, 32'h00B2A3A4, 0);
      vecs[8]  = mk(32'h10010004, 0, 4'h0, 32'h00400004, 0, 4'h0, 32'h00B2A3A4, 0, 32'h00B2A3A4, 0);
      vecs[9]  = mk(32'h10030000, 32'h55555555, 4'hF, 32'h00400000, 0, 4'h0, 32'h00000000, 1, 32'hCAFEBABE, 0);
      vecs[10] = mk(32'h10010000, 0, 4'h0, 32'h00400004, 0, 4'h0, 32'hCAFEBABE, 0, 32'h00B2A3A4, 0);
      vecs[11] = mk(32'h1000FFFC, 0, 4'h0, 32'h00420000, 0, 4'h0, 32'h00000000, 1, 32'h00000000, 1);
      vecs[12] = mk(32'h1002FFFC, 32'h0BADF00D, 4'hF, 32'h0041FFFC, 0, 4'h0, 32'h0BADF00D, 0, 32'h0BADF00D, 0);
      vecs[13] = mk(32'h1002FFFC, 0, 4'h0, 32'h003FFFFC, 32'h12345678, 4'hF, 32'h0BADF00D, 0, 32'h00000000, 1);
      vecs[14] = mk(32'h10010000, 0, 4'h0, 32'h0041FFFC, 0, 4'h0, 32'hCAFEBABE, 0, 32'h0BADF00D, 0);

      // Reset values
      step(); step();
      chk("rst.data0", bus0.data0_o, 0);
      chk("rst.data1", bus0.data1_o, 0);
      chk("rst.err0", 32'(bus0.err0_o), 0);
      chk("rst.err1", 32'(bus0.err1_o), 0);
      chk("rst.ready", 32'(bus0.ld_ready_o), 0);
      chk("rst.busy", 32'(bus0.busy_o), 0);
      chk("rst.ovf", 32'(bus0.ld_ovf_o), 0);
      rst = 1'b0;
      step();

      // Load the two-instruction program
      bus0.ld_start_i = 1; step(); bus0.ld_start_i = 0;
      chk("ld.busy_up", 32'(bus0.busy_o), 1);
      chk("ld.ready_up", 32'(bus0.ld_ready_o), 1);
      for (int i = 0; i < 8; i++) begin
         bus0.ld_valid_i = 1; bus0.ld_data_i = prog[i]; bus0.ld_last_i = (i == 7);
         step();
         if (i == 6) chk("ld.busy_mid", 32'(bus0.busy_o), 1);
      end
      bus0.ld_valid_i = 0; bus0.ld_last_i = 0;
      chk("ld.busy_down", 32'(bus0.busy_o), 0);
      chk("ld.ready_down", 32'(bus0.ld_ready_o), 0);
      chk("ld.ovf", 32'(bus0.ld_ovf_o), 0);

      // Port vectors
      for (int i = 0; i < 15; i++) begin
         bus0.addr0_i = vecs[i].a0; bus0.data0_i = vecs[i].d0; bus0.wr0_i = vecs[i].w0;
         bus0.addr1_i = vecs[i].a1; bus0.data1_i = vecs[i].d1; bus0.wr1_i = vecs[i].w1;
         step();
         chk($sformatf("v%0d.data0", i), bus0.data0_o, vecs[i].x0);
         chk($sformatf("v%0d.err0", i), 32'(bus0.err0_o), 32'(vecs[i].e0));
         chk($sformatf("v%0d.data1", i), bus0.data1_o, vecs[i].x1);
         chk($sformatf("v%0d.err1", i), 32'(bus0.err1_o), 32'(vecs[i].e1));
      end
      bus0.wr0_i = 0; bus0.wr1_i = 0;

      // Start coinciding with a port write, then accesses inhibited while busy
      bus0.addr0_i = 32'h10010020; bus0.data0_i = 32'h77777777; bus0.wr0_i = 4'hF;
      bus0.ld_start_i = 1;
      step();
      bus0.ld_start_i = 0;
      chk("st.data0", bus0.data0_o, 32'h77777777);
      chk("st.busy", 32'(bus0.busy_o), 1);
      bus0.data0_i = 32'h88888888; bus0.addr1_i = 32'h00400020;
      step();
      bus0.wr0_i = 0;
      chk("bz.data0", bus0.data0_o, 0);
      chk("bz.err0", 32'(bus0.err0_o), 0);
      chk("bz.data1", bus0.data1_o, 0);
      bus0.ld_valid_i = 1; bus0.ld_data_i = 8'h99; bus0.ld_last_i = 1;
      step();
      bus0.ld_valid_i = 0; bus0.ld_last_i = 0;
      chk("bz.busy_down", 32'(bus0.busy_o), 0);
      bus0.addr1_i = 32'h00400000;
      step();
      chk("bz.word8", bus0.data0_o, 32'h77777777);
      chk("bz.word0", bus0.data1_o, 32'hCAFEBA99);

      // Reset interrupting a load keeps the bytes already written
      bus0.ld_start_i = 1; step(); bus0.ld_start_i = 0;
      for (int i = 0; i < 3; i++) begin
         bus0.ld_valid_i = 1; bus0.ld_data_i = 8'(8'h11 * (i + 1)); bus0.ld_last_i = 0;
         step();
      end
      bus0.ld_valid_i = 0;
      rst = 1'b1; step(); rst = 1'b0;
      chk("ri.busy", 32'(bus0.busy_o), 0);
      chk("ri.ready", 32'(bus0.ld_ready_o), 0);
      step();
      chk("ri.word0", bus0.data1_o, 32'hCA332211);
      bus0.ld_start_i = 1; step(); bus0.ld_start_i = 0;
      bus0.ld_valid_i = 1; bus0.ld_data_i = 8'h44; bus0.ld_last_i = 1;
      step();
      bus0.ld_valid_i = 0; bus0.ld_last_i = 0;
      step();
      chk("ri.restart", bus0.data1_o, 32'hCA332244);

      // Overflow on the 4-word instance
      bus1.ld_start_i = 1; step(); bus1.ld_start_i = 0;
      chk("ov.busy_up", 32'(bus1.busy_o), 1);
      for (int i = 0; i < 20; i++) begin
         bus1.ld_valid_i = 1; bus1.ld_data_i = 8'(i + 1); bus1.ld_last_i = (i == 19);
         step();
         if (i == 15) chk("ov.ovf_b16", 32'(bus1.ld_ovf_o), 0);
         if (i == 16) chk("ov.ovf_b17", 32'(bus1.ld_ovf_o), 1);
         if (i == 18) chk("ov.busy_b19", 32'(bus1.busy_o), 1);
      end
      bus1.ld_valid_i = 0; bus1.ld_last_i = 0;
      chk("ov.busy_down", 32'(bus1.busy_o), 0);
      chk("ov.ovf_sticky", 32'(bus1.ld_ovf_o), 1);
      bus1.addr0_i = 32'h1001000C; bus1.addr1_i = 32'h00400000;
      step();
      chk("ov.word3", bus1.data0_o, 32'h100F0E0D);
      chk("ov.word0", bus1.data1_o, 32'h04030201);
      bus1.addr0_i = 32'h10010010;
      step();
      chk("ov.oor_err", 32'(bus1.err0_o), 1);
      chk("ov.oor_data", bus1.data0_o, 0);
      bus1.ld_start_i = 1; step(); bus1.ld_start_i = 0;
      chk("ov.ovf_clr", 32'(bus1.ld_ovf_o), 0);
      bus1.ld_valid_i = 1; bus1.ld_data_i = 8'hAA; bus1.ld_last_i = 1;
      step();
      bus1.ld_valid_i = 0; bus1.ld_last_i = 0;
      step();
      chk("ov.reload", bus1.data1_o, 32'h040302AA);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
